// File: rtl/hilo_unit.sv
// HI/LO architectural register pair fed by the sequential divider and multiplier.
// Optional macro HILO_BYPASS_EN forwards staged results to rd_data during COMMIT.
module hilo_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_div,
  input  logic             start_mult,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic             div_zero,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             stall,
  output logic             div0_exc,
  output logic             timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DIV,
    WAIT_MULT,
    COMMIT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] stage_hi;
  logic [WIDTH-1:0] stage_lo;
  logic [CW-1:0]    count;

  // Both wait states share one done/result path selected by the active unit.
  logic             unit_done;
  logic [WIDTH-1:0] unit_hi;
  logic [WIDTH-1:0] unit_lo;

  always_comb begin
    unit_done = 1'b0;
    unit_hi   = '0;
    unit_lo   = '0;
    if (state == WAIT_DIV) begin
      unit_done = div_done;
      unit_hi   = div_hi;
      unit_lo   = div_lo;
    end else if (state == WAIT_MULT) begin
      unit_done = mult_done;
      unit_hi   = mult_hi;
      unit_lo   = mult_lo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      stage_hi    <= '0;
      stage_lo    <= '0;
      count       <= '0;
      div0_exc    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      div0_exc    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= mt_data;
          if (mtlo) lo <= mt_data;
          if (start_div) begin
            state <= WAIT_DIV;
            count <= '0;
          end else if (start_mult) begin
            state <= WAIT_MULT;
            count <= '0;
          end
        end
        WAIT_DIV, WAIT_MULT: begin
          if (state == WAIT_DIV && div_zero) begin
            div0_exc <= 1'b1;
            state    <= IDLE;
          end else if (unit_done) begin
            stage_hi <= unit_hi;
            stage_lo <= unit_lo;
            state    <= COMMIT;
          end else if (count == LAST_COUNT) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        COMMIT: begin
          hi    <= stage_hi;
          lo    <= stage_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign hi_out = hi;
  assign lo_out = lo;

`ifdef HILO_BYPASS_EN
  always_comb begin
    if (state == COMMIT) rd_data = rd_sel ? stage_lo : stage_hi;
    else                 rd_data = rd_sel ? lo : hi;
  end
  assign stall = busy & ((rd_req & (state != COMMIT)) | mthi | mtlo);
`else
  assign rd_data = rd_sel ? lo : hi;
  assign stall   = busy & (rd_req | mthi | mtlo);
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit with hand-computed expectations.
module tb_hilo_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_div, start_mult;
  logic        div_done, div_zero, mult_done;
  logic [31:0] div_hi, div_lo, mult_hi, mult_lo;
  logic        mthi, mtlo, rd_req, rd_sel;
  logic [31:0] mt_data;
  logic [31:0] rd_data, hi_out, lo_out;
  logic        busy, stall, div0_exc, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  hilo_unit #(.WIDTH(32), .TIMEOUT_CYCLES(40)) dut (
    .clock(clock), .reset(reset),
    .start_div(start_div), .start_mult(start_mult),
    .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo), .div_zero(div_zero),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall(stall),
    .div0_exc(div0_exc), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mt_write(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; mt_data = h; tick(); mthi = 1'b0;
    mtlo = 1'b1; mt_data = l; tick(); mtlo = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    int early;
    reset = 1'b0;
    {start_div, start_mult, div_done, div_zero, mult_done} = '0;
    {mthi, mtlo, rd_req, rd_sel} = '0;
    div_hi = '0; div_lo = '0; mult_hi = '0; mult_lo = '0; mt_data = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_exc", {30'd0, div0_exc, timeout_err}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // MTHI+MTLO together, then reset while a divide is pending
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h77;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both_hi", hi_out, 32'h77);
    check("mt_both_lo", lo_out, 32'h77);
    start_div = 1'b1; tick(); start_div = 1'b0;
    check("wait_busy", {31'd0, busy}, 32'd1);
    div_lo = 32'h1234; div_hi = 32'h1234;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi_out, 32'd0);
    check("midrst_lo", lo_out, 32'd0);
    check("midrst_div0", {31'd0, div0_exc}, 32'd0);
    div_lo = '0; div_hi = '0;
    tick();
    reset = 1'b1;
    tick();

    // Full divide: done after 33 wait cycles, commit two edges after done
    mt_write(32'hAAAA, 32'h5555);
    check("mt_hi", hi_out, 32'hAAAA);
    check("mt_lo", lo_out, 32'h5555);
    start_div = 1'b1; tick(); start_div = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 34; i++) begin
      if (busy) bcnt++;
      div_done = (i == 32);
      div_hi   = (i == 32) ? 32'h3 : 32'h0;
      div_lo   = (i == 32) ? 32'h21 : 32'h0;
      rd_req   = (i == 5) || (i == 33);
      rd_sel   = 1'b1;
      #1;
      if (i == 5) check("wait_rd_stall", {31'd0, stall}, 32'd1);
      if (i == 33) begin
        check("commit_hi_old", hi_out, 32'hAAAA);
`ifdef HILO_BYPASS_EN
        check("commit_stall", {31'd0, stall}, 32'd0);
        check("commit_rd_data", rd_data, 32'h21);
`else
        check("commit_stall", {31'd0, stall}, 32'd1);
        check("commit_rd_data", rd_data, 32'h5555);
`endif
      end
      tick();
    end
    div_done = 1'b0; rd_req = 1'b0;
    check("div_busy_cycles", bcnt, 34);
    check("div_idle", {31'd0, busy}, 32'd0);
    check("div_hi", hi_out, 32'h3);
    check("div_lo", lo_out, 32'h21);
    rd_req = 1'b1; rd_sel = 1'b0; #1;
    check("idle_rd_nostall", {31'd0, stall}, 32'd0);
    check("idle_rd_hi", rd_data, 32'h3);
    rd_req = 1'b0;

    // Divide by zero
    mt_write(32'hAAAA, 32'h5555);
    start_div = 1'b1; tick(); start_div = 1'b0;
    div_zero = 1'b1; tick(); div_zero = 1'b0;
    check("div0_pulse", {31'd0, div0_exc}, 32'd1);
    check("div0_idle", {31'd0, busy}, 32'd0);
    check("div0_hi", hi_out, 32'hAAAA);
    check("div0_lo", lo_out, 32'h5555);
    check("div0_no_tmo", {31'd0, timeout_err}, 32'd0);
    tick();
    check("div0_once", {31'd0, div0_exc}, 32'd0);

    // Multiply timeout at edge 40 after start
    start_mult = 1'b1; tick(); start_mult = 1'b0;
    early = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (timeout_err || !busy) early++;
    end
    check("tmo_not_early", early, 0);
    tick();
    check("tmo_pulse", {31'd0, timeout_err}, 32'd1);
    check("tmo_idle", {31'd0, busy}, 32'd0);
    check("tmo_hi", hi_out, 32'hAAAA);
    check("tmo_lo", lo_out, 32'h5555);
    tick();
    check("tmo_once", {31'd0, timeout_err}, 32'd0);

    // MT together with start_mult, then MT during wait is stalled and ignored
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hDEADBEEF; start_mult = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0; start_mult = 1'b0;
    check("mt_start_hi", hi_out, 32'hDEADBEEF);
    check("mt_start_lo", lo_out, 32'hDEADBEEF);
    check("mt_start_busy", {31'd0, busy}, 32'd1);
    mthi = 1'b1; mt_data = 32'h0; #1;
    check("mt_wait_stall", {31'd0, stall}, 32'd1);
    tick();
    mthi = 1'b0;
    check("mt_wait_ignored", hi_out, 32'hDEADBEEF);
    mult_done = 1'b1; mult_hi = 32'h1; mult_lo = 32'h2;
    tick();
    mult_done = 1'b0;
    check("mult_commit_pending", hi_out, 32'hDEADBEEF);
    tick();
    check("mult_hi", hi_out, 32'h1);
    check("mult_lo", lo_out, 32'h2);
    rd_req = 1'b1; rd_sel = 1'b1; #1;
    check("rd_lo_data", rd_data, 32'h2);
    check("rd_lo_stall", {31'd0, stall}, 32'd0);
    rd_req = 1'b0;

    // Simultaneous starts: divide wins, mult_done is ignored
    start_div = 1'b1; start_mult = 1'b1; tick();
    start_div = 1'b0; start_mult = 1'b0;
    mult_done = 1'b1; mult_hi = 32'h99; mult_lo = 32'h98; tick();
    mult_done = 1'b0;
    check("both_start_busy", {31'd0, busy}, 32'd1);
    div_zero = 1'b1; tick(); div_zero = 1'b0;
    check("both_start_div0", {31'd0, div0_exc}, 32'd1);
    check("both_start_hi", hi_out, 32'h1);

    // Start outside IDLE is ignored
    start_mult = 1'b1; tick(); start_mult = 1'b0;
    start_div = 1'b1; tick(); start_div = 1'b0;
    div_zero = 1'b1; tick(); div_zero = 1'b0;
    check("busy_start_ignored", {31'd0, div0_exc}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
